fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage placed directly upstream of the decode/execute core. It owns the fetch PC, issues word requests to instruction memory over a valid/ready request channel, and collects in-order responses in a small reorder-free fetch queue. It presents `{pc, instr}` pairs to decode over a valid/ready handshake. Branch and jump redirects from execute flush the queue and squash in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset.
- `DEPTH`, default 4: fetch queue slots; power of two, ≥2. This is also the maximum number of outstanding requests.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  request valid.
- `imem_req_addr`  out  32  word address; bits [1:0] always 0.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  response valid, in request order, latency ≥1 cycle, no backpressure.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  control-flow redirect (taken BEQ, jump).
- `redirect_pc`  in  32  new fetch PC; bits [1:0] forced to 0 internally.
- `out_valid`  out  1  instruction available to decode.
- `out_pc`  out  32  PC of presented instruction.
- `out_instr`  out  32  presented instruction.
- `out_ready`  in  1  decode consumes.

## Operation
- The fetch PC register `fpc` drives `imem_req_addr`. A request fires on `imem_req_valid && imem_req_ready`, and then `fpc <= fpc + 4`, wrapping modulo 2^32.
- `imem_req_valid` = !reset && !redirect_valid && free slot exists. A slot is allocated at request fire and stores the PC, so capacity counts both in-flight requests and filled entries.
- The slot ring uses a head pointer, an alloc pointer and a fill pointer, each log2(DEPTH) bits and wrapping. Each slot holds `pc`, `instr` and a `filled` flag.
- A response writes `instr` into the slot at the fill pointer, sets `filled` and advances the fill pointer. If `drop_cnt` > 0, the response is discarded instead and `drop_cnt` is decremented.
- The output presents the head slot. `out_valid` = head allocated && filled && !redirect_valid. The slot is freed on `out_valid && out_ready`.
- Redirect cycle:
  - `fpc <= redirect_pc & ~3` and all slots are freed; pointers are reset to equal values.
  - No request fires in this cycle and no output handshake occurs.
  - `drop_cnt <=` number of in-flight, unfilled requests, minus 1 if `imem_rsp_valid` this cycle. That same-cycle response is discarded.
  - The next request fires no earlier than the following cycle.
- Responses received while `drop_cnt` > 0 never reach the queue. A new-stream response cannot be confused with a stale one because responses are in order.
- Priority: reset > redirect > normal operation. A simultaneous free and allocate in the same cycle is legal when the queue is full.
- Reset state:
  - `fpc = RESET_PC`; all slots free; `drop_cnt = 0`.
  - `imem_req_valid = 0`, `imem_req_addr = RESET_PC`, `out_valid = 0`, `out_pc = 0`, `out_instr = 0`.
  - `out_pc` and `out_instr` are 0 whenever `out_valid` = 0.

## Timing
- Cycle 0 is the first cycle with `reset` low; the first request fires in cycle 0 if `imem_req_ready` = 1.
- A request in cycle N with memory latency L gives a response in N+L, and `out_valid` in N+L+1. With bypass (see Configuration), `out_valid` is asserted in N+L.
- Sustained throughput is 1 instr/cycle when L ≤ DEPTH−1 with registered output (DEPTH with bypass) and `out_ready` = 1.
- Redirect in cycle R gives the first new request in R+1 and the first new `out_valid` in R+1+L+1. That is R+1+L with bypass.
- `imem_req_addr` stays stable while `imem_req_valid && !imem_req_ready`, unless a redirect occurs.
- Reset asserted mid-operation discards all state within one cycle. Responses from before reset must not arrive after reset; the memory is reset from the same `reset`.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When the head slot is allocated but unfilled and a non-dropped response for it arrives, the output presents `imem_rsp_data` combinationally in that cycle.
  - `out_valid` = 1 in that case. If `out_ready`, the slot is freed without writing `filled`.
- `FETCH_BYPASS_EN` undefined: the output is driven only from filled slots, which adds one cycle of latency with no combinational path from `imem_rsp_*` to `out_*`.

## Test plan
- Reset release, L=1 memory returning instr = addr ^ 32'hA5A5_0000, `out_ready` = 1:
  - `out_pc` sequence is 0, 4, 8, C… with matching instrs.
  - First `out_valid` is in cycle 2, or in cycle 1 with `FETCH_BYPASS_EN`.
- Backpressure:
  - With `out_ready` = 0, exactly 4 requests fire (0, 4, 8, C), then `imem_req_valid` = 0.
  - Raising `out_ready` yields outputs 0, 4, 8, C, then a request at 0x10.
- `imem_req_ready` = 0 for 5 cycles: `imem_req_addr` holds 0x0 and no output appears. Afterwards the stream continues at 0x0.
- Redirect, L=3, with 3 requests in flight (0x20, 0x24, 0x28): `redirect_pc` = 32'h0000_0103 gives next `out_pc` = 0x100. The three stale responses are never output.
- Redirect in the same cycle as `out_valid && out_ready` with `imem_rsp_valid`:
  - Nothing is consumed and that response is dropped.
  - The sequence resumes at `redirect_pc`.
- `reset` asserted with the queue full and a redirect pending: next cycle `out_valid` = 0, `imem_req_addr` = `RESET_PC`, and `drop_cnt` = 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word requests and queues responses for decode.
// Optional macro FETCH_BYPASS_EN forwards a response straight to the output when it targets the empty head slot.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    // Stale responses can accumulate across back-to-back redirects, so the drop counter has headroom.
    localparam int DW = PW + 2;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [31:0]      fpc_r;
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    alloc_r;
    logic [PW-1:0]    fill_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    pend_r;
    logic [DW-1:0]    drop_cnt_r;
    logic [DEPTH-1:0] filled_r;
    logic [31:0]      pc_r    [DEPTH];
    logic [31:0]      instr_r [DEPTH];

    logic          rsp_live_s;
    logic          head_ok_s;
    logic          byp_s;
    logic          out_fire_s;
    logic          req_fire_s;
    logic          has_free_s;
    logic [CW-1:0] count_nxt_s;
    logic [CW-1:0] pend_nxt_s;
    logic [DW-1:0] drop_nxt_s;

    // Handshake decode, output mux and next-count arithmetic.
    always_comb begin
        rsp_live_s = imem_rsp_valid && (drop_cnt_r == {DW{1'b0}});
        head_ok_s  = (count_r != {CW{1'b0}});
`ifdef FETCH_BYPASS_EN
        byp_s      = head_ok_s && !filled_r[head_r] && rsp_live_s;
`else
        byp_s      = 1'b0;
`endif
        out_valid  = !reset && !redirect_valid && head_ok_s && (filled_r[head_r] || byp_s);
        out_fire_s = out_valid && out_ready;
        // A slot being freed this cycle may be reallocated in the same cycle.
        has_free_s     = (count_r < CW'(DEPTH)) || out_fire_s;
        imem_req_valid = !reset && !redirect_valid && has_free_s;
        imem_req_addr  = fpc_r;
        req_fire_s     = imem_req_valid && imem_req_ready;

        if (out_valid) begin
            out_pc    = pc_r[head_r];
            out_instr = byp_s ? imem_rsp_data : instr_r[head_r];
        end else begin
            out_pc    = 32'h0000_0000;
            out_instr = 32'h0000_0000;
        end

        count_nxt_s = count_r + CW'(req_fire_s) - CW'(out_fire_s);
        pend_nxt_s  = pend_r + CW'(req_fire_s) - CW'(rsp_live_s);

        if (redirect_valid) begin
            drop_nxt_s = drop_cnt_r + DW'(pend_r) - DW'(imem_rsp_valid);
        end else if (imem_rsp_valid && !rsp_live_s) begin
            drop_nxt_s = drop_cnt_r - DW'(1);
        end else begin
            drop_nxt_s = drop_cnt_r;
        end
    end

    // Control state: fetch PC, ring pointers, occupancy and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_r      <= RESET_PC;
            head_r     <= {PW{1'b0}};
            alloc_r    <= {PW{1'b0}};
            fill_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            pend_r     <= {CW{1'b0}};
            drop_cnt_r <= {DW{1'b0}};
            filled_r   <= {DEPTH{1'b0}};
        end else if (redirect_valid) begin
            fpc_r      <= redirect_pc & ~32'd3;
            head_r     <= {PW{1'b0}};
            alloc_r    <= {PW{1'b0}};
            fill_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            pend_r     <= {CW{1'b0}};
            drop_cnt_r <= drop_nxt_s;
            filled_r   <= {DEPTH{1'b0}};
        end else begin
            count_r    <= count_nxt_s;
            pend_r     <= pend_nxt_s;
            drop_cnt_r <= drop_nxt_s;
            if (req_fire_s) begin
                fpc_r   <= fpc_r + 32'd4;
                alloc_r <= alloc_r + PTR_ONE;
            end
            if (rsp_live_s) begin
                fill_r           <= fill_r + PTR_ONE;
                filled_r[fill_r] <= 1'b1;
            end
            // Freeing after filling lets a bypassed slot end up clear.
            if (out_fire_s) begin
                head_r           <= head_r + PTR_ONE;
                filled_r[head_r] <= 1'b0;
            end
        end
    end

    // Slot payload storage; validity is tracked by the control state above.
    always_ff @(posedge clk) begin
        if (req_fire_s) begin
            pc_r[alloc_r] <= fpc_r;
        end
        if (rsp_live_s) begin
            instr_r[fill_r] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: behavioural memory with fixed latency, expected {pc, instr}
// pairs queued at request time and compared when decode consumes them.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XMASK    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          fires = 0;
    int          outs = 0;
    int          first_ov = -1;
    logic [31:0] exp_fpc;
    logic [31:0] first_fire_addr;
    logic [31:0] first_out_pc;
    logic        s_req_valid, s_out_valid, s_rsp_valid, s_fire;
    logic [31:0] s_req_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample at the negedge, update models, advance.
    task automatic tick();
        exp_t e;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].addr ^ XMASK;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #4;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_rsp_valid = imem_rsp_valid;
        s_fire      = imem_req_valid && imem_req_ready;
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (out_valid && out_ready) begin
            if (outs == 0) first_out_pc = out_pc;
            outs++;
            if (sb.size() == 0) begin
                check_eq("out_extra", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check_eq("out_pc", out_pc, e.pc);
                check_eq("out_instr", out_instr, e.instr);
            end
        end else if (!out_valid) begin
            check_eq("idle_pc", out_pc, 32'h0);
            check_eq("idle_instr", out_instr, 32'h0);
        end
        if (redirect_valid) begin
            check_eq("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
            check_eq("out_valid_in_redirect", 32'(out_valid), 32'd0);
            sb.delete();
            exp_fpc = redirect_pc & ~32'd3;
        end else if (s_fire) begin
            check_eq("req_addr", imem_req_addr, exp_fpc);
            if (fires == 0) first_fire_addr = imem_req_addr;
            fires++;
            mq.push_back('{addr: imem_req_addr, due: cyc + lat});
            sb.push_back('{pc: exp_fpc, instr: exp_fpc ^ XMASK});
            exp_fpc = exp_fpc + 32'd4;
        end
        if (imem_rsp_valid) void'(mq.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_models();
        mq.delete();
        sb.delete();
        exp_fpc  = RESET_PC;
        cyc      = 0;
        fires    = 0;
        outs     = 0;
        first_ov = -1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        @(posedge clk);
        #4;
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_req_addr", imem_req_addr, RESET_PC);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_pc", out_pc, 32'h0);
        check_eq("rst_out_instr", out_instr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_models();
    endtask

    initial begin
        bit found;

        // Streaming from reset, L=1.
        lat = 1;
        do_reset();
        repeat (12) tick();
`ifdef FETCH_BYPASS_EN
        check_eq("first_out_cycle", 32'(first_ov), 32'd1);
        check_eq("stream_count", 32'(outs), 32'd11);
`else
        check_eq("first_out_cycle", 32'(first_ov), 32'd2);
        check_eq("stream_count", 32'(outs), 32'd10);
`endif

        // Decode backpressure fills the queue with exactly four requests.
        do_reset();
        out_ready = 1'b0;
        repeat (8) tick();
        check_eq("bp_fires", 32'(fires), 32'd4);
        check_eq("bp_req_valid", 32'(s_req_valid), 32'd0);
        out_ready = 1'b1;
        fires = 0;
        repeat (6) tick();
        check_eq("bp_next_req", first_fire_addr, 32'h0000_0010);
        check_eq("bp_drained", 32'(outs >= 4), 32'd1);

        // Memory not ready: address holds, nothing reaches decode.
        do_reset();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_addr", s_req_addr, 32'h0);
            check_eq("stall_req_valid", 32'(s_req_valid), 32'd1);
            check_eq("stall_out_valid", 32'(s_out_valid), 32'd0);
        end
        imem_req_ready = 1'b1;
        repeat (6) tick();
        check_eq("stall_resume", first_fire_addr, 32'h0);

        // Redirect with L=3 while requests are in flight.
        lat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (s_fire && s_req_addr == 32'h0000_0028) found = 1'b1;
        end
        check_eq("redir_reached_28", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        outs = 0;
        repeat (12) tick();
        check_eq("redir_has_out", 32'(outs > 0), 32'd1);
        check_eq("redir_first_pc", first_out_pc, 32'h0000_0100);

        // Redirect coinciding with a response and a would-be output handshake.
        lat = 1;
        do_reset();
        repeat (6) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        check_eq("coinc_rsp_seen", 32'(s_rsp_valid), 32'd1);
        check_eq("coinc_no_out", 32'(s_out_valid), 32'd0);
        redirect_valid = 1'b0;
        outs = 0;
        repeat (8) tick();
        check_eq("coinc_first_pc", first_out_pc, 32'h0000_0200);

        // Reset with a full queue and a redirect in the same cycle.
        do_reset();
        out_ready = 1'b0;
        repeat (8) tick();
        check_eq("full_out_valid", 32'(s_out_valid), 32'd1);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        clear_models();
        check_eq("rst_drop_cnt", 32'(dut.drop_cnt_r), 32'd0);
        tick();
        check_eq("rst_full_out_valid", 32'(s_out_valid), 32'd0);
        check_eq("rst_full_addr", s_req_addr, RESET_PC);
        repeat (6) tick();
        check_eq("rst_full_restart", 32'(outs > 0), 32'd1);

        // Randomised traffic with occasional redirects, including a PC wrap.
        lat = 2;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            if (i == 150) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'hFFFF_FFF9;
            end else begin
                redirect_valid = ($urandom_range(0, 24) == 0);
                redirect_pc    = $urandom;
            end
            tick();
        end
        redirect_valid = 1'b0;
        check_eq("rand_progress", 32'(outs > 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
